// File: rtl/booth_multiplier_param.sv
// Sequential radix-2 Booth multiplier with serial operand load over a shared bus.
// Signed and unsigned operands share one (WIDTH+1)-bit signed datapath.
module booth_multiplier_param #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_X,
      S_ITER,
      S_OUT_HI,
      S_OUT_LO
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic             r_mode;
   logic [WIDTH:0]   r_y;
   logic [WIDTH:0]   r_a;
   logic [WIDTH:0]   r_x;
   logic             r_xm1;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH:0]   w_sum;
   logic [2*WIDTH+1:0] w_product;
   logic             w_unused_top;

   // One extra bit lets unsigned operands ride the signed Booth datapath.
   function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] v, input logic m);
      return {m & v[WIDTH-1], v};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      busy         = (r_state != S_IDLE);
      done         = 1'b0;
      data_out     = '0;
      case (r_state)
         S_IDLE:   if (start) w_next_state = S_LOAD_X;
         S_LOAD_X: w_next_state = S_ITER;
         S_ITER:   if (r_cnt == CW'(1)) w_next_state = S_OUT_HI;
         S_OUT_HI: begin
            done         = 1'b1;
            data_out     = w_product[2*WIDTH-1:WIDTH];
            w_next_state = S_OUT_LO;
         end
         S_OUT_LO: begin
            done         = 1'b1;
            data_out     = w_product[WIDTH-1:0];
            w_next_state = S_IDLE;
         end
         default:  w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_sum = r_a;
      case ({r_x[0], r_xm1})
         2'b01:   w_sum = r_a + r_y;
         2'b10:   w_sum = r_a - r_y;
         default: w_sum = r_a;
      endcase
   end

   // The two top bits of {A, X} are sign copies and never part of the product.
   assign w_product    = {r_a, r_x};
   assign w_unused_top = &w_product[2*WIDTH+1:2*WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode <= 1'b0;
         r_y    <= '0;
         r_a    <= '0;
         r_x    <= '0;
         r_xm1  <= 1'b0;
         r_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_y    <= ext(data_in, signed_mode);
                  r_mode <= signed_mode;
               end
            end
            S_LOAD_X: begin
               r_x   <= ext(data_in, r_mode);
               r_a   <= '0;
               r_xm1 <= 1'b0;
               r_cnt <= CW'(WIDTH + 1);
            end
            S_ITER: begin
               r_a   <= {w_sum[WIDTH], w_sum[WIDTH:1]};
               r_x   <= {w_sum[0], r_x[WIDTH:1]};
               r_xm1 <= r_x[0];
               r_cnt <= r_cnt - 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Directed bench for booth_multiplier_param at WIDTH 8, 4 and 16.
module tb_booth_multiplier_param;

   logic        clk;
   logic        rst;
   int          cyc;
   int          n_checks;
   int          n_fail;

   logic        start8, sm8, busy8, done8;
   logic [7:0]  din8, dout8;
   logic        start4, sm4, busy4, done4;
   logic [3:0]  din4, dout4;
   logic        start16, sm16, busy16, done16;
   logic [15:0] din16, dout16;

   logic [7:0]  tr_dout [0:13];
   logic        tr_busy [0:13];
   logic        tr_done [0:13];

   booth_multiplier_param #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
      .data_in(din8), .data_out(dout8), .busy(busy8), .done(done8));

   booth_multiplier_param #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
      .data_in(din4), .data_out(dout4), .busy(busy4), .done(done4));

   booth_multiplier_param #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
      .data_in(din16), .data_out(dout16), .busy(busy16), .done(done16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One WIDTH=8 operation from start (cycle 0) to cycle 13; optional extra start pulses.
   task automatic drive_op8(input logic s, input logic [7:0] y, input logic [7:0] x,
                            input logic extra);
      for (int c = 0; c <= 13; c++) begin
         start8 = 1'b0;
         din8   = 8'($urandom);
         sm8    = 1'($urandom);
         if (c == 0) begin
            start8 = 1'b1; din8 = y; sm8 = s;
         end else if (c == 1) begin
            din8 = x; start8 = extra; sm8 = ~s;
         end else if (extra && (c == 5 || c == 11)) begin
            start8 = 1'b1; din8 = 8'h5A; sm8 = ~s;
         end
         tr_dout[c] = dout8;
         tr_busy[c] = busy8;
         tr_done[c] = done8;
         if (c < 13) tick();
      end
      start8 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({busy8, done8, dout8} !== 10'h000) begin
         n_fail++;
         $display("FAIL reset_w8: busy=%b done=%b data_out=%h, want 0 0 00", busy8, done8, dout8);
      end
      n_checks++;
      if ({busy4, done4, dout4, busy16, done16, dout16} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_w4_w16: busy4=%b done4=%b dout4=%h busy16=%b done16=%b dout16=%h, want zeros",
                  busy4, done4, dout4, busy16, done16, dout16);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if ({busy8, done8, dout8} !== 10'h000) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy=%b done=%b data_out=%h, want 0 0 00", busy8, done8, dout8);
      end
   endtask

   task automatic test_signed_timing();
      drive_op8(1'b1, 8'h03, 8'hFB, 1'b0);
      n_checks++;
      if (tr_busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_start_cycle: busy=%b, want 0", tr_busy[0]);
      end
      for (int c = 1; c <= 10; c++) begin
         n_checks++;
         if (tr_busy[c] !== 1'b1 || tr_done[c] !== 1'b0 || tr_dout[c] !== 8'h00) begin
            n_fail++;
            $display("FAIL busy_phase c%0d: busy=%b done=%b data_out=%h, want 1 0 00",
                     c, tr_busy[c], tr_done[c], tr_dout[c]);
         end
      end
      n_checks++;
      if (tr_done[11] !== 1'b1 || tr_busy[11] !== 1'b1 || tr_dout[11] !== 8'hFF) begin
         n_fail++;
         $display("FAIL hi_word_3x-5: done=%b busy=%b data_out=%h, want 1 1 ff",
                  tr_done[11], tr_busy[11], tr_dout[11]);
      end
      n_checks++;
      if (tr_done[12] !== 1'b1 || tr_busy[12] !== 1'b1 || tr_dout[12] !== 8'hF1) begin
         n_fail++;
         $display("FAIL lo_word_3x-5: done=%b busy=%b data_out=%h, want 1 1 f1",
                  tr_done[12], tr_busy[12], tr_dout[12]);
      end
      n_checks++;
      if (tr_done[13] !== 1'b0 || tr_busy[13] !== 1'b0 || tr_dout[13] !== 8'h00) begin
         n_fail++;
         $display("FAIL after_done: done=%b busy=%b data_out=%h, want 0 0 00",
                  tr_done[13], tr_busy[13], tr_dout[13]);
      end
   endtask

   // Hand-computed products: {mode, Y, X, hi, lo}.
   task automatic test_signed_extremes();
      logic [32:0] vec [0:3];
      vec[0] = {1'b1, 8'h80, 8'h80, 8'h40, 8'h00};  // -128 * -128 = 16384
      vec[1] = {1'b1, 8'h80, 8'h7F, 8'hC0, 8'h80};  // -128 * 127 = -16256
      vec[2] = {1'b1, 8'h7F, 8'h7F, 8'h3F, 8'h01};  // 127 * 127 = 16129
      vec[3] = {1'b1, 8'hFF, 8'hFF, 8'h00, 8'h01};  // -1 * -1 = 1
      for (int i = 0; i < 4; i++) begin
         drive_op8(vec[i][32], vec[i][31:24], vec[i][23:16], 1'b0);
         n_checks++;
         if (tr_done[11] !== 1'b1 || tr_dout[11] !== vec[i][15:8] ||
             tr_done[12] !== 1'b1 || tr_dout[12] !== vec[i][7:0]) begin
            n_fail++;
            $display("FAIL signed_vec%0d: got %h/%h done %b%b, want %h/%h done 11", i,
                     tr_dout[11], tr_dout[12], tr_done[11], tr_done[12], vec[i][15:8], vec[i][7:0]);
         end
      end
   endtask

   task automatic test_unsigned();
      logic [32:0] vec [0:3];
      vec[0] = {1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01};  // 255 * 255 = 65025
      vec[1] = {1'b0, 8'h00, 8'hA5, 8'h00, 8'h00};
      vec[2] = {1'b0, 8'h80, 8'h02, 8'h01, 8'h00};  // 128 * 2 = 256
      vec[3] = {1'b0, 8'h03, 8'hFB, 8'h02, 8'hF1};  // 3 * 251 = 753
      for (int i = 0; i < 4; i++) begin
         drive_op8(vec[i][32], vec[i][31:24], vec[i][23:16], 1'b0);
         n_checks++;
         if (tr_done[11] !== 1'b1 || tr_dout[11] !== vec[i][15:8] ||
             tr_done[12] !== 1'b1 || tr_dout[12] !== vec[i][7:0]) begin
            n_fail++;
            $display("FAIL unsigned_vec%0d: got %h/%h done %b%b, want %h/%h done 11", i,
                     tr_dout[11], tr_dout[12], tr_done[11], tr_done[12], vec[i][15:8], vec[i][7:0]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      drive_op8(1'b1, 8'h03, 8'hFB, 1'b1);
      for (int c = 1; c <= 12; c++) begin
         n_checks++;
         if (tr_busy[c] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_held c%0d: busy=%b, want 1", c, tr_busy[c]);
         end
      end
      n_checks++;
      if (tr_done[10] !== 1'b0 || tr_done[11] !== 1'b1 || tr_dout[11] !== 8'hFF ||
          tr_done[12] !== 1'b1 || tr_dout[12] !== 8'hF1 || tr_busy[13] !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_ignored: done10=%b hi=%h lo=%h done=%b%b busy13=%b, want 0 ff f1 11 0",
                  tr_done[10], tr_dout[11], tr_dout[12], tr_done[11], tr_done[12], tr_busy[13]);
      end
   endtask

   task automatic test_reset_mid_iter();
      start8 = 1'b1; din8 = 8'h7F; sm8 = 1'b1;
      tick();
      start8 = 1'b0; din8 = 8'h7F;
      for (int c = 2; c <= 6; c++) tick();
      n_checks++;
      if (busy8 !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_before_abort: busy=%b, want 1", busy8);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({busy8, done8, dout8} !== 10'h000) begin
         n_fail++;
         $display("FAIL abort_mid_iter: busy=%b done=%b data_out=%h, want 0 0 00", busy8, done8, dout8);
      end
      tick();
      drive_op8(1'b0, 8'h0C, 8'h0B, 1'b0);  // 12 * 11 = 132
      n_checks++;
      if (tr_dout[11] !== 8'h00 || tr_dout[12] !== 8'h84 || tr_done[11] !== 1'b1) begin
         n_fail++;
         $display("FAIL after_abort_product: got %h/%h done=%b, want 00/84 done=1",
                  tr_dout[11], tr_dout[12], tr_done[11]);
      end
   endtask

   task automatic test_rst_with_start();
      rst = 1'b1; start8 = 1'b1; din8 = 8'h11; sm8 = 1'b1;
      tick();
      rst = 1'b0; start8 = 1'b0;
      n_checks++;
      if (busy8 !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_beats_start: busy=%b, want 0", busy8);
      end
      tick();
      n_checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0) begin
         n_fail++;
         $display("FAIL still_idle: busy=%b done=%b, want 0 0", busy8, done8);
      end
   endtask

   task automatic test_width4();
      int prev_done;
      int t;
      logic s;
      logic [3:0] y, x;
      logic [7:0] ey, ex, exp_p;
      prev_done = 0;
      for (int k = 0; k < 12; k++) begin
         s = k[0];
         y = (k < 2) ? 4'h8 : 4'($urandom);
         x = (k < 2) ? 4'h8 : 4'($urandom);
         ey = s ? {{4{y[3]}}, y} : {4'h0, y};
         ex = s ? {{4{x[3]}}, x} : {4'h0, x};
         exp_p = ey * ex;
         start4 = 1'b1; din4 = y; sm4 = s;
         tick();
         start4 = 1'b0; din4 = x; sm4 = ~s;
         tick();
         din4 = 4'($urandom);
         t = 2;
         while (!done4 && t < 40) begin
            tick();
            t++;
         end
         n_checks++;
         if (done4 !== 1'b1 || t != 7) begin
            n_fail++;
            $display("FAIL w4_latency k%0d: done at cycle %0d, want 7", k, t);
         end
         n_checks++;
         if (dout4 !== exp_p[7:4]) begin
            n_fail++;
            $display("FAIL w4_hi k%0d: s=%b y=%h x=%h got %h want %h", k, s, y, x, dout4, exp_p[7:4]);
         end
         if (k > 0) begin
            n_checks++;
            if (cyc - prev_done != 9) begin
               n_fail++;
               $display("FAIL w4_spacing k%0d: %0d cycles, want 9", k, cyc - prev_done);
            end
         end
         prev_done = cyc;
         tick();
         n_checks++;
         if (done4 !== 1'b1 || dout4 !== exp_p[3:0]) begin
            n_fail++;
            $display("FAIL w4_lo k%0d: done=%b got %h want %h", k, done4, dout4, exp_p[3:0]);
         end
         tick();
      end
      n_checks++;
      if (busy4 !== 1'b0) begin
         n_fail++;
         $display("FAIL w4_idle_end: busy=%b, want 0", busy4);
      end
   endtask

   task automatic test_width16();
      int prev_done;
      int t;
      logic s;
      logic [15:0] y, x;
      logic [31:0] ey, ex, exp_p;
      prev_done = 0;
      for (int k = 0; k < 10; k++) begin
         s = k[0];
         y = (k < 2) ? 16'h8000 : 16'($urandom);
         x = (k < 2) ? 16'hFFFF : 16'($urandom);
         ey = s ? {{16{y[15]}}, y} : {16'h0, y};
         ex = s ? {{16{x[15]}}, x} : {16'h0, x};
         exp_p = ey * ex;
         start16 = 1'b1; din16 = y; sm16 = s;
         tick();
         start16 = 1'b0; din16 = x; sm16 = ~s;
         tick();
         din16 = 16'($urandom);
         t = 2;
         while (!done16 && t < 60) begin
            tick();
            t++;
         end
         n_checks++;
         if (done16 !== 1'b1 || t != 19) begin
            n_fail++;
            $display("FAIL w16_latency k%0d: done at cycle %0d, want 19", k, t);
         end
         n_checks++;
         if (dout16 !== exp_p[31:16]) begin
            n_fail++;
            $display("FAIL w16_hi k%0d: s=%b y=%h x=%h got %h want %h", k, s, y, x, dout16, exp_p[31:16]);
         end
         if (k > 0) begin
            n_checks++;
            if (cyc - prev_done != 21) begin
               n_fail++;
               $display("FAIL w16_spacing k%0d: %0d cycles, want 21", k, cyc - prev_done);
            end
         end
         prev_done = cyc;
         tick();
         n_checks++;
         if (done16 !== 1'b1 || dout16 !== exp_p[15:0]) begin
            n_fail++;
            $display("FAIL w16_lo k%0d: done=%b got %h want %h", k, done16, dout16, exp_p[15:0]);
         end
         tick();
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      start8 = 1'b0; sm8 = 1'b0; din8 = '0;
      start4 = 1'b0; sm4 = 1'b0; din4 = '0;
      start16 = 1'b0; sm16 = 1'b0; din16 = '0;
      #1;
      test_reset();
      test_signed_timing();
      test_signed_extremes();
      test_unsigned();
      test_start_while_busy();
      test_reset_mid_iter();
      test_rst_with_start();
      test_width4();
      test_width16();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
